player_bullet_controller: RTL and testbench
===========================================

Name: player_bullet_controller

Overview:
- Owns the player's bullet pool: spawns bullets on the fire button, moves them upward on a fixed tick, and retires them at the screen top or on a hit.
- Sits directly upstream of the enemy controllers: drives their flattened bullet position/active buses and consumes their one-cycle bullet_hit pulses.
- Runs in the 25 MHz pixel-clock domain, alongside the player movement logic that supplies player_x/player_y.

Parameters:
- BULLET_COUNT, 8, number of bullet slots (enemy side is fixed at 8).
- MOVE_DIV, 250_000, clk25 cycles per movement tick.
- SPEED, 4, pixels moved upward per tick.
- COOLDOWN, 2_500_000, minimum cycles between two accepted shots.
- X_OFFSET, 12, added to player_x at spawn (centres an 8 px bullet on a 32 px sprite).
- Y_OFFSET, 8, subtracted from player_y at spawn.

Ports:
- clk25  input  1  system clock, 25 MHz.
- reset  input  1  asynchronous, active-low reset.
- fire  input  1  debounced fire button, asynchronous to clk25, active-high.
- player_x  input  10  player sprite left edge, in pixels.
- player_y  input  10  player sprite top edge, in pixels.
- bullet_hit  input  BULLET_COUNT  one-cycle hit pulses from the enemy controllers, bit j = slot j.
- bullet_x_flat  output  10*BULLET_COUNT  slot j x at [j*10 +: 10].
- bullet_y_flat  output  10*BULLET_COUNT  slot j y at [j*10 +: 10].
- bullet_active_flat  output  BULLET_COUNT  slot j active.
- fire_ack  output  1  one-cycle pulse in the cycle after a bullet is spawned (for sound/score).

Behaviour:
- Reset (async assert, sync release): all slots inactive, all x/y = 0, fire_ack = 0, cooldown = 0, move counter = 0, synchronizer flops = 0.
- Fire path: two-flop synchronizer, then rising-edge detect on the second flop.
  - fire first sampled high at edge N: edge detected after N+1; spawn registered at edge N+2.
  - bullet_active_flat goes high after N+2; fire_ack goes high after N+3 for exactly one cycle.
- Spawn conditions (all required): edge detected, cooldown == 0, at least one free slot.
  - Allocation picks the lowest-index slot whose registered active bit is 0.
  - Spawned slot: x = player_x + X_OFFSET, y = player_y - Y_OFFSET, both truncated to 10 bits. If player_y < Y_OFFSET, y = 0 instead.
  - Cooldown counter is loaded with COOLDOWN - 1 and decrements to 0.
- Dropped requests: if the pool is full or cooldown != 0, the request is dropped. No queuing, no cooldown reload, no fire_ack.
- Move counter: counts 0..MOVE_DIV-1 and wraps. The tick is the cycle where the count equals MOVE_DIV-1.
- On a tick, for each active slot:
  - if y < SPEED, the slot becomes inactive;
  - otherwise y -= SPEED;
  - x never changes.
- Hit: bullet_hit[j] = 1 clears active[j] at the next edge. A hit on an inactive slot is ignored.
- Simultaneous events:
  - Hit and tick on the same slot: the hit wins (inactive); y may be left at either value.
  - A slot freed this cycle (by hit or top exit) is not reallocatable until the next cycle.
  - Spawn and tick in the same cycle: the new bullet is not moved on that tick.
- Inactive slots hold their last x/y; consumers must gate on active.
- Reset asserted mid-flight clears everything immediately. A fire held across reset release does not spawn, because no rising edge is seen.
- All outputs are registered; the flat buses are direct concatenations of the slot registers.

Optional Feature:
- Macro: PLAYER_BULLET_AUTOFIRE_EN.
- Defined: while the synchronized fire is held high, a new spawn is attempted every cycle cooldown == 0. Sustained fire therefore yields one bullet per COOLDOWN cycles, subject to free slots.
- Undefined: only rising edges spawn; holding the button fires exactly once.

Test Plan:
- Bench parameters for all scenarios: MOVE_DIV=4, SPEED=4, COOLDOWN=10.
- Single shot: player_x=300, player_y=400, fire pulse -> slot 0 active at x=312, y=392 two edges after the first sample. fire_ack follows one cycle later. y becomes 388, 384, ... every 4 cycles.
- Cooldown: two fire edges 5 cycles apart -> only slot 0 spawns. A third edge 12 cycles after the first -> slot 1 spawns.
- Pool full: fill all 8 slots, pulse bullet_hit=8'b0000_0100, fire again after cooldown -> slot 2 is reused; no other slot changes.
- Top exit: spawn with player_y=10 (y=2) -> the first tick deactivates it; active bit 0 at the next edge.
- Hit vs tick collision: assert bullet_hit[0] in the tick cycle -> slot 0 inactive, never reactivated. A hit on an inactive slot 5 -> no change.
- Reset mid-flight: 3 active bullets, pull reset low asynchronously between edges -> all outputs 0 immediately. Fire held through release -> no spawn (with PLAYER_BULLET_AUTOFIRE_EN undefined).

Source files
------------

// File: rtl/player_bullet_controller.sv
// player_bullet_controller: player bullet pool with fire sync/edge detect, cooldown, upward motion and hit/top retirement.
// Optional PLAYER_BULLET_AUTOFIRE_EN: a held fire button re-spawns whenever the cooldown has expired.
module player_bullet_controller #(
   parameter int BULLET_COUNT = 8,
   parameter int MOVE_DIV     = 250_000,
   parameter int SPEED        = 4,
   parameter int COOLDOWN     = 2_500_000,
   parameter int X_OFFSET     = 12,
   parameter int Y_OFFSET     = 8
) (
   input  logic                       clk25,
   input  logic                       reset,
   input  logic                       fire,
   input  logic [9:0]                 player_x,
   input  logic [9:0]                 player_y,
   input  logic [BULLET_COUNT-1:0]    bullet_hit,
   output logic [10*BULLET_COUNT-1:0] bullet_x_flat,
   output logic [10*BULLET_COUNT-1:0] bullet_y_flat,
   output logic [BULLET_COUNT-1:0]    bullet_active_flat,
   output logic                       fire_ack
);
   localparam int MW = $clog2(MOVE_DIV + 1);
   localparam int CW = $clog2(COOLDOWN + 1);
   logic                    fs1_q, fs2_q, fs3_q;
   logic [1:0]              warm_q;
   logic [MW-1:0]           mv_q;
   logic [CW-1:0]           cd_q;
   logic                    spawned_q, ack_q;
   logic [BULLET_COUNT-1:0] act_q, act_d, gnt;
   logic [9:0]              x_q [BULLET_COUNT];
   logic [9:0]              x_d [BULLET_COUNT];
   logic [9:0]              y_q [BULLET_COUNT];
   logic [9:0]              y_d [BULLET_COUNT];
   logic                    req, tick, spawn;
   logic [9:0]              sx, sy;
   // warm_q gates edge detection until fs3_q holds a real post-reset sample, so a button held through reset never fires
`ifdef PLAYER_BULLET_AUTOFIRE_EN
   assign req = fs2_q & (&warm_q);
`else
   assign req = fs2_q & ~fs3_q & (&warm_q);
`endif
   assign tick  = mv_q == MW'(MOVE_DIV - 1);
   assign gnt   = ~act_q & (act_q + BULLET_COUNT'(1));
   assign spawn = req & (cd_q == '0) & (|gnt);
   assign sx    = player_x + 10'(X_OFFSET);
   assign sy    = (player_y < 10'(Y_OFFSET)) ? '0 : player_y - 10'(Y_OFFSET);
   always_comb begin
      act_d = act_q;
      x_d   = x_q;
      y_d   = y_q;
      for (int j = 0; j < BULLET_COUNT; j++) begin
         if (tick && act_q[j] && !bullet_hit[j]) begin
            act_d[j] = y_q[j] >= 10'(SPEED);
            y_d[j]   = (y_q[j] >= 10'(SPEED)) ? y_q[j] - 10'(SPEED) : y_q[j];
         end
         if (bullet_hit[j]) act_d[j] = 1'b0;
         if (spawn && gnt[j]) begin
            act_d[j] = 1'b1;
            x_d[j]   = sx;
            y_d[j]   = sy;
         end
      end
   end
   always_ff @(posedge clk25 or negedge reset) begin
      if (!reset) begin
         fs1_q     <= 1'b0;
         fs2_q     <= 1'b0;
         fs3_q     <= 1'b0;
         warm_q    <= '0;
         mv_q      <= '0;
         cd_q      <= '0;
         spawned_q <= 1'b0;
         ack_q     <= 1'b0;
         act_q     <= '0;
         for (int j = 0; j < BULLET_COUNT; j++) begin
            x_q[j] <= '0;
            y_q[j] <= '0;
         end
      end else begin
         fs1_q     <= fire;
         fs2_q     <= fs1_q;
         fs3_q     <= fs2_q;
         warm_q    <= (&warm_q) ? warm_q : warm_q + 2'd1;
         mv_q      <= tick ? '0 : mv_q + MW'(1);
         cd_q      <= spawn ? CW'(COOLDOWN - 1) : (cd_q != '0) ? cd_q - CW'(1) : cd_q;
         spawned_q <= spawn;
         ack_q     <= spawned_q;
         act_q     <= act_d;
         x_q       <= x_d;
         y_q       <= y_d;
      end
   end
   genvar g;
   for (g = 0; g < BULLET_COUNT; g++) begin : g_flat
      assign bullet_x_flat[g*10 +: 10] = x_q[g];
      assign bullet_y_flat[g*10 +: 10] = y_q[g];
   end
   assign bullet_active_flat = act_q;
   assign fire_ack           = ack_q;
endmodule

// File: tb/tb_player_bullet_controller.sv
// tb_player_bullet_controller: directed scenarios with literal checks plus a per-cycle behavioural model comparison.
module tb_player_bullet_controller;
   localparam int MD = 4, SP = 4, CD = 10, N = 8;
   logic          clk25 = 0, reset = 0, fire = 0;
   logic [9:0]    px = 300, py = 400;
   logic [N-1:0]  hit = '0;
   logic [10*N-1:0] xf, yf;
   logic [N-1:0]  af;
   logic          ack;
   int total = 0, bad = 0;

   player_bullet_controller #(.BULLET_COUNT(N), .MOVE_DIV(MD), .SPEED(SP), .COOLDOWN(CD),
      .X_OFFSET(12), .Y_OFFSET(8)) dut (
      .clk25(clk25), .reset(reset), .fire(fire), .player_x(px), .player_y(py),
      .bullet_hit(hit), .bullet_x_flat(xf), .bullet_y_flat(yf),
      .bullet_active_flat(af), .fire_ack(ack));

   always #20 clk25 = ~clk25;

   // model: edge count since release, fire sample history, timestamp of last accepted shot
   int  ne = 0, last_sp = -1000, slot;
   bit  h0, h1, h2, m_ack, pend, req, tick;
   bit  m_act [N];
   int  m_x [N], m_y [N];
   always @(posedge clk25 or negedge reset) begin
      if (!reset) begin
         ne = 0; last_sp = -1000; m_ack = 0; pend = 0; h0 = 0; h1 = 0; h2 = 0;
         for (int j = 0; j < N; j++) begin m_act[j] = 0; m_x[j] = 0; m_y[j] = 0; end
      end else begin
         req  = (ne >= 3) && h1 && !h2;
         tick = (ne % MD) == MD - 1;
         slot = -1;
         for (int j = N - 1; j >= 0; j--) if (!m_act[j]) slot = j;
         m_ack = pend;
         pend  = 0;
         for (int j = 0; j < N; j++)
            if (m_act[j]) begin
               if (hit[j]) m_act[j] = 0;
               else if (tick) begin
                  if (m_y[j] < SP) m_act[j] = 0;
                  else m_y[j] = m_y[j] - SP;
               end
            end
         if (req && (ne - last_sp >= CD) && slot >= 0) begin
            m_act[slot] = 1;
            m_x[slot]   = (int'(px) + 12) % 1024;
            m_y[slot]   = (py < 8) ? 0 : int'(py) - 8;
            last_sp     = ne;
            pend        = 1;
         end
         h2 = h1; h1 = h0; h0 = fire;
         ne++;
      end
   end

   logic [10*N-1:0] ex, ey;
   logic [N-1:0]    ea;
   always @(negedge clk25) begin
      for (int j = 0; j < N; j++) begin
         ex[j*10 +: 10] = 10'(m_x[j]);
         ey[j*10 +: 10] = 10'(m_y[j]);
         ea[j]          = m_act[j];
      end
      total++;
      if (xf !== ex || yf !== ey || af !== ea || ack !== m_ack) begin
         bad++;
         $display("FAIL cycle ne=%0d: got act=%h ack=%b x=%h y=%h want act=%h ack=%b x=%h y=%h",
            ne, af, ack, xf, yf, ea, m_ack, ex, ey);
      end
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, got, want);
      end
   endtask

   function automatic logic [9:0] xo(input int j); return xf[j*10 +: 10]; endfunction
   function automatic logic [9:0] yo(input int j); return yf[j*10 +: 10]; endfunction

   task automatic at_edge(input int e);
      while (ne <= e) @(negedge clk25);
   endtask

   task automatic pulse(input int e);
      at_edge(e - 1); fire = 1;
      at_edge(e);     fire = 0;
   endtask

   task automatic do_reset();
      @(negedge clk25); #5 reset = 0; fire = 0; hit = '0;
      @(negedge clk25); reset = 1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: got running want finished");
      $fatal(1);
   end

   initial begin
      repeat (2) @(negedge clk25);
      chk("reset_act", af, 0);
      chk("reset_ack", ack, 0);
      reset = 1;
      // single shot
      pulse(4);
      at_edge(5); chk("a_not_yet", af, 0);
      at_edge(6); chk("a_act", af, 1); chk("a_x0", xo(0), 312); chk("a_y0", yo(0), 392); chk("a_ack0", ack, 0);
      at_edge(7); chk("a_ack1", ack, 1); chk("a_y_t1", yo(0), 388);
      at_edge(8); chk("a_ack2", ack, 0);
      at_edge(11); chk("a_y_t2", yo(0), 384);
      // cooldown
      do_reset();
      pulse(4); pulse(9);
      at_edge(11); chk("b_drop_act", af, 1);
      at_edge(12); chk("b_drop_ack", ack, 0);
      pulse(16);
      at_edge(18); chk("b_act", af, 3); chk("b_y1", yo(1), 392); chk("b_y0", yo(0), 380);
      at_edge(19); chk("b_ack", ack, 1);
      // pool full and slot reuse
      do_reset();
      for (int k = 0; k < 8; k++) pulse(4 + 10 * k);
      at_edge(76); chk("c_full", af, 8'hff);
      pulse(84);
      at_edge(87); chk("c_full_drop_act", af, 8'hff); chk("c_full_drop_ack", ack, 0);
      hit = 8'b0000_0100;
      at_edge(88); hit = '0; chk("c_hit", af, 8'hfb);
      px = 100; py = 200;
      pulse(90);
      at_edge(92); chk("c_reuse", af, 8'hff); chk("c_x2", xo(2), 112); chk("c_y2", yo(2), 192);
      chk("c_x0", xo(0), 312); chk("c_y0", yo(0), 304);
      at_edge(93); chk("c_ack", ack, 1);
      // top exit, x wrap, y clamp
      do_reset();
      px = 1020; py = 10;
      pulse(4);
      at_edge(6); chk("d_act", af, 1); chk("d_xwrap", xo(0), 8); chk("d_y", yo(0), 2);
      at_edge(7); chk("d_exit", af, 0);
      py = 5;
      pulse(16);
      at_edge(18); chk("d_clamp_act", af, 1); chk("d_clamp_y", yo(0), 0);
      at_edge(19); chk("d_clamp_exit", af, 0);
      // hit vs tick, hit on inactive slot
      do_reset();
      px = 300; py = 400;
      pulse(4);
      at_edge(10); chk("e_pre", af, 1); chk("e_pre_y", yo(0), 388);
      hit = 8'h01;
      at_edge(11); hit = 8'h20; chk("e_hit_tick", af, 0);
      at_edge(12); hit = '0; chk("e_hit_idle", af, 0);
      at_edge(20); chk("e_stay", af, 0);
      // reset mid-flight, fire held across release
      do_reset();
      pulse(4); pulse(14); pulse(24);
      at_edge(26); chk("f_three", af, 7);
      at_edge(27); chk("f_ack", ack, 1);
      #5 reset = 0; fire = 1;
      #1 chk("f_rst_act", af, 0); chk("f_rst_ack", ack, 0);
      chk("f_rst_x", 32'(|xf), 0); chk("f_rst_y", 32'(|yf), 0);
      @(negedge clk25); reset = 1;
      at_edge(10); chk("f_held_act", af, 0); chk("f_held_ack", ack, 0);
      fire = 0;
      at_edge(12);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
